id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- ID→EX pipeline register of the five-stage MIPS core.
- Sits directly downstream of the ID-stage immediate extender and register file.
- Captures the decoded instruction, PC, operand values, extended immediate, destination index and control word for the EX stage.
- Inserts bubbles on load-use stalls, holds while EX is busy (mult/div), flushes on redirect, and refreshes latched rs/rt values from the write-back port so no operand goes stale.

Parameters:
- CTRL_W, 16, width of the opaque control bundle from the ID decoder
- TNEW_W, 2, width of the result-latency (Tnew) field used by the hazard unit

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- stall_d  in  1  load-use stall; ID holds, EX receives a bubble
- hold_e  in  1  EX busy; all E outputs keep their values
- flush_e  in  1  discard EX contents (redirect/exception)
- instr_D  in  32  instruction word in ID
- pc_D  in  32  PC of ID instruction
- rs_data_D  in  32  register-file read port 1
- rt_data_D  in  32  register-file read port 2
- imm_D  in  32  extended immediate from the extender
- a3_D  in  5  destination register index (0 = none)
- tnew_D  in  TNEW_W  cycles from ID until the result exists
- ctrl_D  in  CTRL_W  decoded control bundle
- we_W  in  1  write-back write enable
- a3_W  in  5  write-back destination
- wd_W  in  32  write-back data
- instr_E, pc_E, rs_data_E, rt_data_E, imm_E  out  32 each  registered copies
- a3_E  out  5  registered destination
- tnew_E  out  TNEW_W  latency remaining in EX
- ctrl_E  out  CTRL_W  registered control
- valid_E  out  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset (async assert, sync release): every output is 0. instr_E=0 is a canonical nop. valid_E=0.
- Per-edge priority: reset > flush_e > hold_e > stall_d > normal load.
- flush_e=1: load bubble (all outputs 0, valid_E=0), regardless of hold_e or stall_d.
- hold_e=1 (no flush): all fields keep their values, except operand refresh below.
- stall_d=1 (no flush, no hold): load bubble identical to flush.
- Normal load, latency 1 cycle:
  - instr/pc/imm/a3/ctrl captured from *_D.
  - valid_E=1.
  - tnew_E = tnew_D-1, saturating at 0.
- Load-time bypass: rs index = instr_D[25:21], rt index = instr_D[20:16].
  - If we_W=1, a3_W!=0 and a3_W==rs index: rs_data_E<=wd_W; otherwise rs_data_D.
  - Same rule independently for rt.
  - Both may hit at once (rs==rt).
- Hold-time refresh: while hold_e=1, the same comparison uses instr_E[25:21] / instr_E[20:16]. A hit updates only rs_data_E / rt_data_E, so a value retiring from WB during a mult/div hold is not lost.
- Register $0 is never bypassed or refreshed; its value stays as read from the register file.
- Bypass and refresh are independent of valid_E. A bubble (instr 0) indexes $0, so no hit occurs.
- No combinational path from any input to any output.

Decomposition:
- Shared package (cpu_pkg): NOP_INSTR=32'h0, RS_MSB/LSB=25/21, RT_MSB/LSB=20/16, CTRL_W, TNEW_W.
- One natural sub-module: wb_bypass_sel. It is a combinational 5-bit compare plus 32-bit mux, instantiated four times (rs/rt × load/hold).

Test Plan:
- Reset mid-stream: assert reset asynchronously between edges → all outputs 0 immediately and valid_E=0; the first normal load after release captures as usual.
- Normal load: instr_D=32'h8C430004 (lw), pc_D=32'h3004, imm_D=32'h4, tnew_D=2 → next edge: instr_E=8C430004, pc_E=3004, tnew_E=1, valid_E=1. With tnew_D=0 → tnew_E=0.
- Load bypass: instr_D rs=3, rt=3, rs_data_D=rt_data_D=5, we_W=1, a3_W=3, wd_W=32'hDEAD → rs_data_E=rt_data_E=DEAD. Same stimulus with a3_W=0 → both outputs 5.
- Stall bubble: stall_d=1 with a valid add in ID → all E outputs 0, valid_E=0. On release, the add is captured.
- Hold refresh: instr_E rs=8; hold_e=1 for 3 cycles; in cycle 2 we_W=1, a3_W=8, wd_W=32'h1234 → rs_data_E=1234, all other fields unchanged. Same case with a3_W=9 → no change.
- Priority: flush_e=1, hold_e=1, stall_d=1 together → bubble. hold_e=1, stall_d=1 → previous contents held, not a bubble.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the MIPS pipeline registers
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int CTRL_W = 16;
  localparam int TNEW_W = 2;

endpackage

// File: rtl/wb_bypass_sel.sv
// rtl/wb_bypass_sel.sv - select write-back data over a register-file value on index match
module wb_bypass_sel (
  input  logic        i_we,
  input  logic [4:0]  i_a3,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_idx,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_hit
);

  // $0 is hard-wired, so a write-back aimed at it never forwards
  assign o_hit  = i_we && (i_a3 != 5'd0) && (i_a3 == i_idx);
  assign o_data = o_hit ? i_wd : i_data;

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID to EX pipeline register with bubble, hold, flush and WB operand refresh
module id_ex_reg
  import cpu_pkg::*;
#(
  parameter int CTRL_W = cpu_pkg::CTRL_W,
  parameter int TNEW_W = cpu_pkg::TNEW_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_d,
  input  logic              hold_e,
  input  logic              flush_e,
  input  logic [31:0]       instr_D,
  input  logic [31:0]       pc_D,
  input  logic [31:0]       rs_data_D,
  input  logic [31:0]       rt_data_D,
  input  logic [31:0]       imm_D,
  input  logic [4:0]        a3_D,
  input  logic [TNEW_W-1:0] tnew_D,
  input  logic [CTRL_W-1:0] ctrl_D,
  input  logic              we_W,
  input  logic [4:0]        a3_W,
  input  logic [31:0]       wd_W,
  output logic [31:0]       instr_E,
  output logic [31:0]       pc_E,
  output logic [31:0]       rs_data_E,
  output logic [31:0]       rt_data_E,
  output logic [31:0]       imm_E,
  output logic [4:0]        a3_E,
  output logic [TNEW_W-1:0] tnew_E,
  output logic [CTRL_W-1:0] ctrl_E,
  output logic              valid_E
);

  logic [31:0]       w_rs_load, w_rt_load, w_rs_hold, w_rt_hold;
  logic              w_rs_load_hit, w_rt_load_hit, w_rs_hold_hit, w_rt_hold_hit;
  logic [TNEW_W-1:0] w_tnew_next;

  wb_bypass_sel u_rs_load (
    .i_we(we_W), .i_a3(a3_W), .i_wd(wd_W),
    .i_idx(instr_D[RS_MSB:RS_LSB]), .i_data(rs_data_D),
    .o_data(w_rs_load), .o_hit(w_rs_load_hit)
  );

  wb_bypass_sel u_rt_load (
    .i_we(we_W), .i_a3(a3_W), .i_wd(wd_W),
    .i_idx(instr_D[RT_MSB:RT_LSB]), .i_data(rt_data_D),
    .o_data(w_rt_load), .o_hit(w_rt_load_hit)
  );

  // While EX is held, the latched operands track WB so a retiring value is not lost
  wb_bypass_sel u_rs_hold (
    .i_we(we_W), .i_a3(a3_W), .i_wd(wd_W),
    .i_idx(instr_E[RS_MSB:RS_LSB]), .i_data(rs_data_E),
    .o_data(w_rs_hold), .o_hit(w_rs_hold_hit)
  );

  wb_bypass_sel u_rt_hold (
    .i_we(we_W), .i_a3(a3_W), .i_wd(wd_W),
    .i_idx(instr_E[RT_MSB:RT_LSB]), .i_data(rt_data_E),
    .o_data(w_rt_hold), .o_hit(w_rt_hold_hit)
  );

  assign w_tnew_next = (tnew_D == '0) ? '0 : tnew_D - 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_E   <= NOP_INSTR;
      pc_E      <= '0;
      rs_data_E <= '0;
      rt_data_E <= '0;
      imm_E     <= '0;
      a3_E      <= '0;
      tnew_E    <= '0;
      ctrl_E    <= '0;
      valid_E   <= 1'b0;
    end else if (flush_e || (!hold_e && stall_d)) begin
      instr_E   <= NOP_INSTR;
      pc_E      <= '0;
      rs_data_E <= '0;
      rt_data_E <= '0;
      imm_E     <= '0;
      a3_E      <= '0;
      tnew_E    <= '0;
      ctrl_E    <= '0;
      valid_E   <= 1'b0;
    end else if (hold_e) begin
      rs_data_E <= w_rs_hold;
      rt_data_E <= w_rt_hold;
    end else begin
      instr_E   <= instr_D;
      pc_E      <= pc_D;
      rs_data_E <= w_rs_load;
      rt_data_E <= w_rt_load;
      imm_E     <= imm_D;
      a3_E      <= a3_D;
      tnew_E    <= w_tnew_next;
      ctrl_E    <= ctrl_D;
      valid_E   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - directed self-checking bench for id_ex_reg
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        reset, stall_d, hold_e, flush_e;
  logic [31:0] instr_D, pc_D, rs_data_D, rt_data_D, imm_D;
  logic [4:0]  a3_D;
  logic [1:0]  tnew_D;
  logic [15:0] ctrl_D;
  logic        we_W;
  logic [4:0]  a3_W;
  logic [31:0] wd_W;
  logic [31:0] instr_E, pc_E, rs_data_E, rt_data_E, imm_E;
  logic [4:0]  a3_E;
  logic [1:0]  tnew_E;
  logic [15:0] ctrl_E;
  logic        valid_E;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .stall_d(stall_d), .hold_e(hold_e), .flush_e(flush_e),
    .instr_D(instr_D), .pc_D(pc_D), .rs_data_D(rs_data_D), .rt_data_D(rt_data_D),
    .imm_D(imm_D), .a3_D(a3_D), .tnew_D(tnew_D), .ctrl_D(ctrl_D),
    .we_W(we_W), .a3_W(a3_W), .wd_W(wd_W),
    .instr_E(instr_E), .pc_E(pc_E), .rs_data_E(rs_data_E), .rt_data_E(rt_data_E),
    .imm_E(imm_E), .a3_E(a3_E), .tnew_E(tnew_E), .ctrl_E(ctrl_E), .valid_E(valid_E)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_d = 0; hold_e = 0; flush_e = 0;
    instr_D = 0; pc_D = 0; rs_data_D = 0; rt_data_D = 0; imm_D = 0;
    a3_D = 0; tnew_D = 0; ctrl_D = 0; we_W = 0; a3_W = 0; wd_W = 0;
  endtask

  task automatic drive_d(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic [4:0] a3,
                         input logic [1:0] tn, input logic [15:0] ctl);
    instr_D = ins; pc_D = pc; rs_data_D = rs; rt_data_D = rt;
    imm_D = imm; a3_D = a3; tnew_D = tn; ctrl_D = ctl;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step();
    checks++;
    if ({instr_E, pc_E, rs_data_E, rt_data_E, imm_E, a3_E, tnew_E, ctrl_E, valid_E} !== '0) begin
      failures++; $display("FAIL reset_state got valid=%b instr=%h pc=%h", valid_E, instr_E, pc_E);
    end
    reset = 0;
    drive_d(32'h8C430004, 32'h3004, 32'h7, 32'h8, 32'h4, 5'd3, 2'd2, 16'hA5A5);
    step();
    checks++;
    if (valid_E !== 1'b1 || instr_E !== 32'h8C430004) begin
      failures++; $display("FAIL pre_reset_load got valid=%b instr=%h want 1/8c430004", valid_E, instr_E);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({instr_E, pc_E, rs_data_E, rt_data_E, imm_E, a3_E, tnew_E, ctrl_E, valid_E} !== '0) begin
      failures++; $display("FAIL async_reset got valid=%b instr=%h pc=%h want zeros", valid_E, instr_E, pc_E);
    end
    @(negedge clk);
    reset = 0;
    step();
    checks++;
    if (valid_E !== 1'b1 || pc_E !== 32'h3004 || ctrl_E !== 16'hA5A5) begin
      failures++; $display("FAIL post_reset_load got valid=%b pc=%h ctrl=%h want 1/3004/a5a5", valid_E, pc_E, ctrl_E);
    end
  endtask

  task automatic test_normal_load();
    idle_inputs();
    drive_d(32'h8C430004, 32'h3004, 32'h10, 32'h20, 32'h4, 5'd3, 2'd2, 16'h0123);
    step();
    checks++;
    if (instr_E !== 32'h8C430004 || pc_E !== 32'h3004 || imm_E !== 32'h4) begin
      failures++; $display("FAIL load_fields got instr=%h pc=%h imm=%h want 8c430004/3004/4", instr_E, pc_E, imm_E);
    end
    checks++;
    if (tnew_E !== 2'd1 || valid_E !== 1'b1 || a3_E !== 5'd3) begin
      failures++; $display("FAIL load_tnew got tnew=%0d valid=%b a3=%0d want 1/1/3", tnew_E, valid_E, a3_E);
    end
    checks++;
    if (rs_data_E !== 32'h10 || rt_data_E !== 32'h20 || ctrl_E !== 16'h0123) begin
      failures++; $display("FAIL load_data got rs=%h rt=%h ctrl=%h want 10/20/0123", rs_data_E, rt_data_E, ctrl_E);
    end
    tnew_D = 2'd0;
    step();
    checks++;
    if (tnew_E !== 2'd0) begin
      failures++; $display("FAIL tnew_saturate got %0d want 0", tnew_E);
    end
    tnew_D = 2'd3;
    step();
    checks++;
    if (tnew_E !== 2'd2) begin
      failures++; $display("FAIL tnew_max got %0d want 2", tnew_E);
    end
  endtask

  task automatic test_load_bypass();
    idle_inputs();
    drive_d(32'h00631020, 32'h4000, 32'h5, 32'h5, 32'h0, 5'd2, 2'd1, 16'h1);
    we_W = 1; a3_W = 5'd3; wd_W = 32'hDEAD;
    step();
    checks++;
    if (rs_data_E !== 32'hDEAD || rt_data_E !== 32'hDEAD) begin
      failures++; $display("FAIL bypass_both got rs=%h rt=%h want dead/dead", rs_data_E, rt_data_E);
    end
    a3_W = 5'd0;
    step();
    checks++;
    if (rs_data_E !== 32'h5 || rt_data_E !== 32'h5) begin
      failures++; $display("FAIL bypass_r0 got rs=%h rt=%h want 5/5", rs_data_E, rt_data_E);
    end
    drive_d(32'h010B5020, 32'h4004, 32'h1, 32'h2, 32'h0, 5'd10, 2'd1, 16'h1);
    a3_W = 5'd11; wd_W = 32'hBEEF;
    step();
    checks++;
    if (rs_data_E !== 32'h1 || rt_data_E !== 32'hBEEF) begin
      failures++; $display("FAIL bypass_rt_only got rs=%h rt=%h want 1/beef", rs_data_E, rt_data_E);
    end
    we_W = 0;
    step();
    checks++;
    if (rt_data_E !== 32'h2) begin
      failures++; $display("FAIL bypass_we0 got rt=%h want 2", rt_data_E);
    end
  endtask

  task automatic test_stall_bubble();
    idle_inputs();
    drive_d(32'h00631020, 32'h5000, 32'h33, 32'h44, 32'h0, 5'd2, 2'd1, 16'h00FF);
    step();
    stall_d = 1;
    step();
    checks++;
    if ({instr_E, pc_E, rs_data_E, rt_data_E, imm_E, a3_E, tnew_E, ctrl_E, valid_E} !== '0) begin
      failures++; $display("FAIL stall_bubble got valid=%b instr=%h pc=%h want zeros", valid_E, instr_E, pc_E);
    end
    stall_d = 0;
    step();
    checks++;
    if (valid_E !== 1'b1 || instr_E !== 32'h00631020 || pc_E !== 32'h5000 || rs_data_E !== 32'h33) begin
      failures++; $display("FAIL stall_release got valid=%b instr=%h pc=%h rs=%h", valid_E, instr_E, pc_E, rs_data_E);
    end
  endtask

  task automatic test_hold_refresh(input logic [4:0] wb_idx, input logic [31:0] want_rs);
    idle_inputs();
    drive_d(32'h010B5020, 32'h6000, 32'h11, 32'h22, 32'h9, 5'd10, 2'd2, 16'h0C0C);
    step();
    hold_e = 1;
    drive_d(32'hFFFFFFFF, 32'h7000, 32'h99, 32'h99, 32'h99, 5'd31, 2'd3, 16'hFFFF);
    step();
    we_W = 1; a3_W = wb_idx; wd_W = 32'h1234;
    step();
    we_W = 0;
    step();
    checks++;
    if (rs_data_E !== want_rs || rt_data_E !== 32'h22) begin
      failures++; $display("FAIL hold_refresh a3_W=%0d got rs=%h rt=%h want %h/22", wb_idx, rs_data_E, rt_data_E, want_rs);
    end
    checks++;
    if (instr_E !== 32'h010B5020 || pc_E !== 32'h6000 || imm_E !== 32'h9 || a3_E !== 5'd10 ||
        tnew_E !== 2'd1 || ctrl_E !== 16'h0C0C || valid_E !== 1'b1) begin
      failures++; $display("FAIL hold_fields got instr=%h pc=%h imm=%h a3=%0d tnew=%0d ctrl=%h valid=%b",
                           instr_E, pc_E, imm_E, a3_E, tnew_E, ctrl_E, valid_E);
    end
    hold_e = 0;
  endtask

  task automatic test_priority();
    idle_inputs();
    drive_d(32'h8C430004, 32'h8000, 32'h1, 32'h2, 32'h4, 5'd3, 2'd2, 16'h5555);
    step();
    flush_e = 1; hold_e = 1; stall_d = 1;
    step();
    checks++;
    if ({instr_E, pc_E, rs_data_E, rt_data_E, imm_E, a3_E, tnew_E, ctrl_E, valid_E} !== '0) begin
      failures++; $display("FAIL prio_flush got valid=%b instr=%h pc=%h want zeros", valid_E, instr_E, pc_E);
    end
    flush_e = 0; hold_e = 0; stall_d = 0;
    step();
    hold_e = 1; stall_d = 1;
    drive_d(32'h00631020, 32'h9000, 32'h7, 32'h7, 32'h0, 5'd2, 2'd0, 16'h0);
    step();
    checks++;
    if (valid_E !== 1'b1 || instr_E !== 32'h8C430004 || pc_E !== 32'h8000 || ctrl_E !== 16'h5555) begin
      failures++; $display("FAIL prio_hold_over_stall got valid=%b instr=%h pc=%h ctrl=%h", valid_E, instr_E, pc_E, ctrl_E);
    end
    hold_e = 0; stall_d = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_normal_load();
    test_load_bypass();
    test_stall_bubble();
    test_hold_refresh(5'd8, 32'h1234);
    test_hold_refresh(5'd9, 32'h11);
    test_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
